// File: rtl/hub75_fb_loader.sv
// Raster pixel stream to HUB75 frame buffer write-in port: fills the line buffer,
// commits each line with swap/store, and flips the frame after the last line.
module hub75_fb_loader #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic                   frame_swap,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int LW = LOG_N_BANKS + LOG_N_ROWS;
  localparam logic [LW-1:0]         LAST_LINE = LW'(N_BANKS * N_ROWS - 1);
  localparam logic [LOG_N_COLS-1:0] LAST_COL  = LOG_N_COLS'(N_COLS - 1);

  localparam logic [2:0] S_FILL     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_STORE    = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_SWAP     = 3'd4;

  logic [2:0]            state;
  logic [LOG_N_COLS-1:0] col;
  logic [LW-1:0]         line;   // {bank, row}
  logic                  run;    // keeps in_ready low while in reset
  logic                  flush_first;

  logic accept, last_pix, early_last, missing_last, err_set;

  assign in_ready     = run && (state == S_FILL);
  assign wr_row_swap  = (state == S_STORE);
  assign wr_row_store = (state == S_STORE);
  assign frame_swap   = (state == S_SWAP);

  assign accept       = in_valid && in_ready;
  assign last_pix     = (line == LAST_LINE) && (col == LAST_COL);
  assign early_last   = accept && in_last && !last_pix;
  assign missing_last = accept && !in_last && last_pix;
  assign err_set      = early_last || missing_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FILL;
      col          <= '0;
      line         <= '0;
      run          <= 1'b0;
      flush_first  <= 1'b0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      wr_col_addr  <= '0;
      wr_bank_addr <= '0;
      wr_row_addr  <= '0;
      err          <= 1'b0;
    end else begin
      run   <= 1'b1;
      wr_en <= 1'b0;
      err   <= (err && !err_clr) || err_set;
      case (state)
        S_FILL: begin
          if (accept) begin
            wr_en       <= 1'b1;
            wr_data     <= in_data;
            wr_col_addr <= col;
            // A premature in_last drops the partial line and restarts the frame.
            if (early_last) begin
              col  <= '0;
              line <= '0;
            end else if (col == LAST_COL) begin
              state <= S_WAIT_RDY;
            end else begin
              col <= col + LOG_N_COLS'(1);
            end
          end
        end
        S_WAIT_RDY: begin
          if (wr_row_rdy) begin
            state        <= S_STORE;
            wr_bank_addr <= line[LW-1:LOG_N_ROWS];
            wr_row_addr  <= line[LOG_N_ROWS-1:0];
          end
        end
        S_STORE: begin
          col  <= '0;
          line <= line + LW'(1);
          if (line == LAST_LINE) begin
            state       <= S_FLUSH;
            flush_first <= 1'b1;
          end else begin
            state <= S_FILL;
          end
        end
        S_FLUSH: begin
          // rdy may still reflect the pre-store state on the first cycle
          flush_first <= 1'b0;
          if (!flush_first && wr_row_rdy) state <= S_SWAP;
        end
        S_SWAP: begin
          line  <= '0;
          state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Randomized bench for hub75_fb_loader against a frame-position reference model.
module tb_hub75_fb_loader;
  localparam int NB = 2, NR = 4, NC = 8, BD = 24;
  localparam int NPIX = NB * NR * NC;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [BD-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [0:0]    wr_bank_addr;
  logic [1:0]    wr_row_addr;
  logic          wr_row_store, wr_row_rdy, wr_row_swap;
  logic [BD-1:0] wr_data;
  logic [2:0]    wr_col_addr;
  logic          wr_en, frame_swap, err;
  logic          err_clr = 1'b0;

  int n_chk = 0, n_pass = 0;

  hub75_fb_loader #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr),
    .wr_row_store(wr_row_store), .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap),
    .wr_data(wr_data), .wr_col_addr(wr_col_addr), .wr_en(wr_en), .frame_swap(frame_swap),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // write-in port model: ready drops for 3 cycles after each store
  int   rdy_cnt;
  logic hold_low = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_cnt <= 0;
    else if (wr_row_store) rdy_cnt <= 3;
    else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
  assign wr_row_rdy = (rdy_cnt == 0) && !hold_low;

  // observed traffic
  logic [26:0] got_wr[$];
  int          got_line[$];
  logic [23:0] got_sd[$];
  logic [23:0] lbuf[NC];
  int          fs_cnt, viol;

  always @(negedge clk) if (rst_n) begin
    if (wr_en) begin
      got_wr.push_back({wr_col_addr, wr_data});
      lbuf[wr_col_addr] = wr_data;
    end
    if (wr_row_store) begin
      got_line.push_back(int'({wr_bank_addr, wr_row_addr}));
      for (int k = 0; k < NC; k++) got_sd.push_back(lbuf[k]);
    end
    if (frame_swap) fs_cnt++;
    if ((wr_en && (wr_row_store || wr_row_swap || frame_swap)) || (wr_row_store != wr_row_swap))
      viol++;
  end

  // reference model: walks frame position per accepted pixel
  typedef struct packed { logic [23:0] d; logic last; } px_t;
  px_t         px_q[$];
  logic [26:0] exp_wr[$];
  int          exp_line[$];
  logic [23:0] exp_sd[$];
  int          exp_fs;
  logic        exp_err;

  function automatic void run_model();
    int pos;
    logic [23:0] lb[NC];
    exp_wr.delete(); exp_line.delete(); exp_sd.delete();
    exp_fs = 0; exp_err = 1'b0; pos = 0;
    foreach (px_q[i]) begin
      int c;
      c = pos % NC;
      exp_wr.push_back({3'(c), px_q[i].d});
      if (px_q[i].last && pos != NPIX - 1) begin
        exp_err = 1'b1;
        pos = 0;
      end else begin
        lb[c] = px_q[i].d;
        if (c == NC - 1) begin
          exp_line.push_back(pos / NC);
          for (int k = 0; k < NC; k++) exp_sd.push_back(lb[k]);
        end
        if (pos == NPIX - 1) begin
          exp_fs++;
          if (!px_q[i].last) exp_err = 1'b1;
          pos = 0;
        end else pos++;
      end
    end
  endfunction

  function automatic int diffs();
    int n = 0;
    if (got_wr.size() != exp_wr.size()) n++;
    else foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) n++;
    if (got_line.size() != exp_line.size()) n++;
    else foreach (exp_line[i]) if (got_line[i] != exp_line[i]) n++;
    if (got_sd.size() != exp_sd.size()) n++;
    else foreach (exp_sd[i]) if (got_sd[i] !== exp_sd[i]) n++;
    return n;
  endfunction

  task automatic clear_mon();
    got_wr.delete(); got_line.delete(); got_sd.delete();
    fs_cnt = 0; viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0; hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
  endtask

  task automatic send(input logic [23:0] d, input logic last, input int gap);
    int n;
    while ($urandom_range(99) < gap) begin
      in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last; n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) send(px_q[i].d, px_q[i].last, gap);
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input int fs_exp, input logic err_exp);
    int d;
    run_model();
    d = diffs();
    n_chk++; if (d != 0) $display("FAIL %s_traffic: %0d differing items want 0", name, d); else n_pass++;
    n_chk++; if (fs_cnt != fs_exp) $display("FAIL %s_frame_swap: got %0d want %0d", name, fs_cnt, fs_exp); else n_pass++;
    n_chk++; if (err !== err_exp) $display("FAIL %s_err: got %0b want %0b", name, err, err_exp); else n_pass++;
    n_chk++; if (viol != 0) $display("FAIL %s_overlap: %0d cycles want 0", name, viol); else n_pass++;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({in_ready, wr_row_store, wr_row_swap, wr_en, frame_swap, err,
                wr_bank_addr, wr_row_addr, wr_data, wr_col_addr});
  endfunction

  task automatic fill_frame(input bit rnd, input bit with_last);
    px_q.delete();
    for (int i = 0; i < NPIX; i++)
      px_q.push_back('{d: rnd ? 24'($urandom) : 24'(i), last: with_last && (i == NPIX - 1)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", out_vec()); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_frame();
    do_reset();
    fill_frame(0, 1);
    send_range(0, NPIX - 1, 0);
    settle();
    check_frame("frame", 1, 1'b0);
  endtask

  task automatic test_backpressure();
    int n, nw, ns, hi;
    do_reset();
    fill_frame(1, 1);
    send_range(0, NC - 1, 0);
    n = 0;
    while (got_line.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++; if (got_line.size() != 1) $display("FAIL bp_first_store: got %0d stores want 1", got_line.size()); else n_pass++;
    hold_low = 1'b1;
    send_range(NC, 2 * NC - 1, 0);
    repeat (2) @(posedge clk);
    #1;
    nw = got_wr.size(); ns = got_line.size(); hi = 0;
    repeat (20) begin @(posedge clk); #1; if (in_ready) hi++; end
    n_chk++; if (hi != 0) $display("FAIL bp_in_ready: high %0d cycles want 0", hi); else n_pass++;
    n_chk++; if (got_wr.size() != nw || got_line.size() != ns)
      $display("FAIL bp_stall: wr %0d st %0d want wr %0d st %0d", got_wr.size(), got_line.size(), nw, ns);
    else n_pass++;
    hold_low = 1'b0;
    send_range(2 * NC, NPIX - 1, 0);
    settle();
    check_frame("bp", 1, 1'b0);
  endtask

  task automatic test_gaps();
    do_reset();
    fill_frame(0, 1);
    send_range(0, NPIX - 1, 50);
    settle();
    check_frame("gaps", 1, 1'b0);
  endtask

  task automatic test_early_last();
    do_reset();
    px_q.delete();
    for (int i = 0; i <= 20; i++) px_q.push_back('{d: 24'($urandom), last: (i == 20)});
    for (int i = 0; i < NC; i++) px_q.push_back('{d: 24'($urandom), last: 1'b0});
    send_range(0, px_q.size() - 1, 30);
    settle();
    check_frame("early", 0, 1'b1);
    n_chk++; if (got_line.size() != 3 || got_line[2] != 0)
      $display("FAIL early_restart_line: got %0d stores want 3 ending at line 0", got_line.size());
    else n_pass++;
    n_chk++; if (got_wr.size() < 22 || got_wr[21][26:24] != 3'd0)
      $display("FAIL early_restart_col: got %0d writes want first post-error col 0", got_wr.size());
    else n_pass++;
  endtask

  task automatic test_missing_last();
    do_reset();
    fill_frame(1, 0);
    send_range(0, NPIX - 1, 20);
    settle();
    check_frame("nolast", 1, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_chk++; if (err !== 1'b0) $display("FAIL err_clr: got %0b want 0", err); else n_pass++;
    err_clr = 1'b1;
    send(24'h123456, 1'b1, 0);
    err_clr = 1'b0;
    n_chk++; if (err !== 1'b1) $display("FAIL err_clr_vs_set: got %0b want 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(24'h0, 1'b1, 0);
    for (int i = 0; i < 13; i++) send(24'($urandom), 1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (out_vec() !== '0) $display("FAIL midreset_outputs: got %h want 0", out_vec()); else n_pass++;
    n_chk++; if (fs_cnt != 0) $display("FAIL midreset_frame_swap: got %0d want 0", fs_cnt); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    px_q.delete();
    for (int i = 0; i < NC; i++) px_q.push_back('{d: 24'($urandom), last: 1'b0});
    send_range(0, NC - 1, 0);
    settle();
    check_frame("midreset", 0, 1'b0);
    n_chk++; if (got_line.size() != 1 || got_line[0] != 0)
      $display("FAIL midreset_line: got %0d stores want 1 at line 0", got_line.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_gaps();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
